// File: rtl/fma_pkg.sv
// Shared definitions for the FMA dot-product scheduler: operand widths, FSM states,
// and the index-width helper used to size lane counters.
package fma_pkg;

  localparam int FMA_AW = 32;
  localparam int FMA_CW = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A single lane still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fma_lat_tracker.sv
// Tag shift register that travels alongside the FMA pipeline so each returning
// result can be matched to its lane and to whether it closes that lane's sum.
module fma_lat_tracker
  import fma_pkg::*;
#(
  parameter int LAT = 4,
  parameter int LW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_live,
  input  logic [LW-1:0] i_lane,
  input  logic          i_last,
  output logic          o_live,
  output logic [LW-1:0] o_lane,
  output logic          o_last
);

  logic [LW+1:0] r_tag [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= {i_live, i_lane, i_last};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_live = r_tag[LAT-1][LW+1];
  assign o_lane = r_tag[LAT-1][LW:1];
  assign o_last = r_tag[LAT-1][0];

endmodule

// File: rtl/fma_dot_scheduler.sv
// Drives a pipelined a*b+c unit to compute LANES interleaved dot products,
// recirculating each lane's partial sum as the next c operand.
module fma_dot_scheduler
  import fma_pkg::*;
#(
  parameter  int LANES   = 4,
  parameter  int FMA_LAT = 4,
  parameter  int KMAX    = 256,
  localparam int KW      = $clog2(KMAX + 1),
  localparam int LW      = idx_w(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMA_AW-1:0] in_a,
  input  logic [FMA_AW-1:0] in_b,
  output logic [FMA_AW-1:0] fma_a,
  output logic [FMA_AW-1:0] fma_b,
  output logic [FMA_CW-1:0] fma_c,
  output logic              fma_issue,
  input  logic [FMA_CW-1:0] fma_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FMA_CW-1:0] res_data,
  output logic [LW-1:0]     res_lane
);

  state_e            r_state, w_state_nxt;
  logic [LW-1:0]     r_lane_cnt, r_out_ptr;
  logic [KW-1:0]     r_step_cnt, r_klen;
  logic [FMA_CW-1:0] r_acc [LANES];
  logic [LANES-1:0]  r_acc_rdy, r_fin;
  logic              r_done;
  logic [LW-1:0]     r_iss_lane;
  logic              r_iss_last;

  logic              w_start_acc, w_hs, w_lane_wrap, w_step_last, w_last_pair;
  logic              w_pop, w_pop_last, w_in_ready;
  logic              w_ret_live, w_ret_last;
  logic [LW-1:0]     w_ret_lane;

  assign w_start_acc = (r_state == IDLE) && start && (k_len != '0);
  // Step 0 starts from c=0, so it never has to wait for a returning partial.
  assign w_in_ready  = (r_state == RUN) &&
                       ((r_step_cnt == '0) || r_acc_rdy[r_lane_cnt]);
  assign w_hs        = in_valid && w_in_ready;
  assign w_lane_wrap = (r_lane_cnt == LW'(LANES - 1));
  assign w_step_last = (r_step_cnt == (r_klen - KW'(1)));
  assign w_last_pair = w_hs && w_lane_wrap && w_step_last;
  assign w_pop       = res_valid && res_ready;
  assign w_pop_last  = w_pop && (r_out_ptr == LW'(LANES - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_acc) w_state_nxt = RUN;
      RUN:     if (w_last_pair) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_pop_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_step_cnt <= '0;
      r_klen     <= '0;
      r_out_ptr  <= '0;
    end else begin
      if (w_start_acc) begin
        r_klen     <= k_len;
        r_lane_cnt <= '0;
        r_step_cnt <= '0;
        r_out_ptr  <= '0;
      end else if (w_hs) begin
        if (w_lane_wrap) begin
          r_lane_cnt <= '0;
          r_step_cnt <= r_step_cnt + KW'(1);
        end else begin
          r_lane_cnt <= r_lane_cnt + LW'(1);
        end
      end
      if (w_pop) r_out_ptr <= w_pop_last ? '0 : r_out_ptr + LW'(1);
    end
  end

  // Issue stage: operands and recirculated partial sum registered toward the FMA
  always_ff @(posedge clk) begin
    if (rst) begin
      fma_a      <= '0;
      fma_b      <= '0;
      fma_c      <= '0;
      fma_issue  <= 1'b0;
      r_iss_lane <= '0;
      r_iss_last <= 1'b0;
    end else begin
      fma_issue  <= w_hs;
      r_iss_lane <= r_lane_cnt;
      r_iss_last <= w_step_last;
      if (w_hs) begin
        fma_a <= in_a;
        fma_b <= in_b;
        fma_c <= (r_step_cnt == '0) ? '0 : r_acc[r_lane_cnt];
      end
    end
  end

  fma_lat_tracker #(
    .LAT (FMA_LAT),
    .LW  (LW)
  ) u_trk (
    .clk    (clk),
    .rst    (rst),
    .i_live (fma_issue),
    .i_lane (r_iss_lane),
    .i_last (r_iss_last),
    .o_live (w_ret_live),
    .o_lane (w_ret_lane),
    .o_last (w_ret_last)
  );

  // Return stage: a live tag exiting the tracker lines up with its fma_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_rdy <= '0;
      r_fin     <= '0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else begin
      if (w_ret_live) begin
        r_acc[w_ret_lane]     <= fma_out;
        r_acc_rdy[w_ret_lane] <= 1'b1;
        if (w_ret_last) r_fin[w_ret_lane] <= 1'b1;
      end
      if (w_hs)  r_acc_rdy[r_lane_cnt] <= 1'b0;
      if (w_pop) r_fin[r_out_ptr]      <= 1'b0;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign in_ready  = w_in_ready;
  assign res_valid = r_fin[r_out_ptr];
  assign res_data  = r_acc[r_out_ptr];
  assign res_lane  = r_out_ptr;

endmodule

// File: tb/tb_fma_dot_scheduler.sv
// Scoreboard bench: ideal FMA model with FMA_LAT register stages, golden per-lane sums
// queued at job start and compared as the scheduler emits results.
module tb_fma_dot_scheduler;

  localparam int LANES   = 4;
  localparam int FMA_LAT = 4;
  localparam int KMAX    = 32;
  localparam int KW      = $clog2(KMAX + 1);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BUDGET  = 5000;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [KW-1:0] k_len;
  logic          in_valid, in_ready;
  logic [31:0]   in_a, in_b, fma_a, fma_b;
  logic [63:0]   fma_c, fma_out, res_data;
  logic          fma_issue, res_valid, res_ready;
  logic [LW-1:0] res_lane;

  always #5 clk = ~clk;

  fma_dot_scheduler #(
    .LANES   (LANES),
    .FMA_LAT (FMA_LAT),
    .KMAX    (KMAX)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .fma_a     (fma_a),
    .fma_b     (fma_b),
    .fma_c     (fma_c),
    .fma_issue (fma_issue),
    .fma_out   (fma_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_lane  (res_lane)
  );

  // Ideal FMA: idle slots carry a poison value so mistimed captures show up
  logic [63:0] fma_pipe [FMA_LAT];
  always @(posedge clk) begin
    fma_pipe[0] <= fma_issue ? (64'(fma_a) * 64'(fma_b) + fma_c) : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < FMA_LAT; i++) fma_pipe[i] <= fma_pipe[i-1];
  end
  assign fma_out = fma_pipe[FMA_LAT-1];

  typedef struct {
    logic [LW-1:0] lane;
    logic [63:0]   data;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] op_a [LANES*KMAX];
  logic [31:0] op_b [LANES*KMAX];
  bit          feed_done;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%h want=0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic feed(input int n, input int vgap, input int spur);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < n && cyc < BUDGET) begin
      in_valid = ($urandom_range(99) >= vgap);
      in_a     = op_a[idx];
      in_b     = op_b[idx];
      if (idx == spur) begin
        start = 1'b1;
        k_len = KW'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      check_eq("busy_run", busy, 1);
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    feed_done = 1'b1;
    check_eq("feed_cnt", idx, n);
  endtask

  task automatic consume(input int rgap, input bit hold);
    int   pops = 0;
    int   cyc  = 0;
    exp_t e;
    if (hold) begin
      res_ready = 1'b0;
      while (!(feed_done && res_valid) && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check_eq("hold_vld", res_valid, 1);
        check_eq("hold_lane", res_lane, 0);
        check_eq("hold_data", res_data, sb_q[0].data);
      end
    end
    cyc = 0;
    while (pops < LANES && cyc < BUDGET) begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(99) >= rgap);
      @(negedge clk);
      if (res_valid && res_ready) begin
        e = sb_q.pop_front();
        check_eq("res_lane", res_lane, e.lane);
        check_eq("res_data", res_data, e.data);
        check_eq("busy_pop", busy, 1);
        pops++;
      end
      cyc++;
    end
    check_eq("res_cnt", pops, LANES);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", done, 1);
    check_eq("busy_end", busy, 0);
    @(negedge clk);
    check_eq("done_clear", done, 0);
  endtask

  // mode 0: a=b=lane+step+1, 1: a=b=2, 2: a=b=all-ones, other: random
  task automatic run_job(input int klen, input int mode, input int vgap, input int rgap,
                         input bit hold, input int spur);
    logic [63:0] sum [LANES];
    logic [31:0] a, b;
    for (int l = 0; l < LANES; l++) sum[l] = '0;
    for (int s = 0; s < klen; s++) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          0:       begin a = 32'(l + s + 1); b = a;  end
          1:       begin a = 32'd2;          b = a;  end
          2:       begin a = '1;             b = '1; end
          default: begin a = $urandom;       b = $urandom; end
        endcase
        op_a[s*LANES + l] = a;
        op_b[s*LANES + l] = b;
        sum[l] = sum[l] + {32'b0, a} * {32'b0, b};
      end
    end
    for (int l = 0; l < LANES; l++) sb_q.push_back('{lane: LW'(l), data: sum[l]});
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(klen);
    @(posedge clk); #1;
    start     = 1'b0;
    feed_done = 1'b0;
    fork
      feed(klen * LANES, vgap, spur);
      consume(rgap, hold);
    join
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0; feed_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_issue", fma_issue, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_fma_a", fma_a, 0);
    check_eq("rst_fma_c", fma_c, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_lane", res_lane, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(3, 0, 0, 0, 1'b0, -1);
    run_job(4, 1, 0, 0, 1'b0, -1);
    run_job(2, 2, 0, 0, 1'b0, -1);
    run_job(3, 0, 0, 0, 1'b1, 5);

    @(posedge clk); #1;
    start = 1'b1;
    k_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("klen0_busy", busy, 0);
    check_eq("klen0_in_ready", in_ready, 0);

    // Abort a job with operands in flight; last-step tags must not surface.
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(2);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 6 && cyc < 200) begin
      in_a = $urandom;
      in_b = $urandom;
      @(negedge clk);
      if (in_ready) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("abort_fed", cnt, 6);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("abort_res_valid", res_valid, 0);
    end
    run_job(1, 3, 0, 0, 1'b0, -1);

    for (int j = 0; j < 200; j++) begin
      run_job($urandom_range(KMAX, 1), 3, $urandom_range(50), $urandom_range(50), 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
